// File: rtl/pwm_gen_core.sv
// Prescaled PWM timer with a complementary dead-time output pair and shadow registers that load at period boundaries.
// Define PWM_CENTER_ALIGN_EN to build the up/down counter; without it the core is edge-aligned only.
module pwm_gen_core #(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8,
  parameter int PSC_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             cfg_en,
  input  logic             cfg_mode,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic [DT_W-1:0]  cfg_deadtime,
  input  logic [PSC_W-1:0] cfg_prescale,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic [CNT_W-1:0] cnt_value,
  output logic             period_irq,
  output logic             load_pending
);

  logic             en_q;
  logic             start;
  logic             run;
  logic             tick;
  logic             boundary;
  logic             shadow_load;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PSC_W-1:0] psc;
  logic [CNT_W-1:0] period_a;
  logic [CNT_W-1:0] duty_a;
  logic [DT_W-1:0]  deadtime_a;
  logic [PSC_W-1:0] prescale_a;
  logic [DT_W-1:0]  dt_cnt;
  logic [DT_W-1:0]  dt_nxt;
  logic             raw;
  logic             raw_nxt;
  logic             gap_clear;

  assign start       = cfg_en & ~en_q;
  assign run         = cfg_en & en_q;
  assign tick        = (psc == prescale_a);
  assign boundary    = run & tick & (cnt_nxt == '0);
  assign shadow_load = start | (boundary & load_pending);
  assign raw_nxt     = (cnt < duty_a);
  assign cnt_value   = cnt;

`ifdef PWM_CENTER_ALIGN_EN
  logic mode_a;
  logic dir_down;

  always_comb begin
    cnt_nxt = (cnt >= period_a) ? '0 : cnt + CNT_W'(1);
    if (mode_a) begin
      // cnt == 0 at the top only happens with period_a == 0: hold at zero
      if (dir_down || (cnt >= period_a)) begin
        cnt_nxt = (cnt == '0) ? '0 : cnt - CNT_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mode_a   <= 1'b0;
      dir_down <= 1'b0;
    end else begin
      if (!run) begin
        dir_down <= 1'b0;
      end else if (tick) begin
        dir_down <= (cnt_nxt != '0) && (cnt_nxt < cnt);
      end
      if (shadow_load) begin
        mode_a <= cfg_mode;
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = cfg_mode;

  always_comb begin
    cnt_nxt = (cnt >= period_a) ? '0 : cnt + CNT_W'(1);
  end
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q         <= 1'b0;
      cnt          <= '0;
      psc          <= '0;
      period_irq   <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      en_q       <= cfg_en;
      period_irq <= boundary;
      if (!run) begin
        cnt <= '0;
        psc <= '0;
      end else if (tick) begin
        cnt <= cnt_nxt;
        psc <= '0;
      end else begin
        psc <= psc + PSC_W'(1);
      end
      // a write landing on the boundary stays queued for the next one
      if (start || boundary) begin
        load_pending <= cfg_load;
      end else begin
        load_pending <= load_pending | cfg_load;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      period_a   <= '0;
      duty_a     <= '0;
      deadtime_a <= '0;
      prescale_a <= '0;
    end else if (shadow_load) begin
      period_a   <= cfg_period;
      duty_a     <= cfg_duty;
      deadtime_a <= cfg_deadtime;
      prescale_a <= cfg_prescale;
    end
  end

  always_comb begin
    dt_nxt = '0;
    if (raw_nxt != raw) begin
      dt_nxt = deadtime_a;
    end else if (dt_cnt != '0) begin
      dt_nxt = dt_cnt - DT_W'(1);
    end
  end

  assign gap_clear = (dt_nxt == '0);

  // outputs are registered so neither side can glitch high during a dead-time gap
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      raw    <= 1'b0;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else if (!run) begin
      raw    <= 1'b0;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      raw    <= raw_nxt;
      dt_cnt <= dt_nxt;
      pwm_h  <= raw_nxt & gap_clear;
      pwm_l  <= ~raw_nxt & gap_clear;
    end
  end

endmodule
